// File: rtl/instr_fetch_ctrl.sv
// MIPS32 instruction-fetch controller: owns the PC, fetches words through a shared
// combinational memory port, and hands instructions to decode through a one-entry output register.
module instr_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clock,
    input  logic        Reset_n,
    output logic [31:0] MemAddress,
    input  logic [31:0] MemInstruction,
    output logic [31:0] Instruction,
    output logic [31:0] InstrPC,
    output logic        InstrValid,
    input  logic        InstrReady,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    input  logic        Halt,
    input  logic        DbgReq,
    input  logic [31:0] DbgAddr,
    output logic        DbgGnt,
    output logic [31:0] DbgData,
    output logic        DbgValid,
    output logic        Fault
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_FAULT  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        instr_valid_q, instr_valid_d;
    logic [31:0] dbg_data_q, dbg_data_d;
    logic        dbg_valid_q, dbg_valid_d;
    logic        fault_q, fault_d;
    logic        last_dbg_q, last_dbg_d;

    logic        fetch_wants;
    logic        dbg_win;
    logic        fetch_fire;
    logic        redirect_take;
    logic        redirect_bad;
    logic        port_dbg;

    // Port arbitration: debug wins ties, but never twice in a row while fetch is waiting.
    always_comb begin
        fetch_wants   = (state_q == ST_RUN) && !Halt && !Redirect &&
                        (!instr_valid_q || InstrReady);
        dbg_win       = DbgReq && !(last_dbg_q && fetch_wants);
        fetch_fire    = fetch_wants && !dbg_win;
        redirect_take = Redirect && (state_q != ST_FAULT);
        redirect_bad  = redirect_take && (RedirectPC[1:0] != 2'b00);
    end

    // While in reset the flops already sit at reset values; only the outputs need masking.
    assign port_dbg   = dbg_win && Reset_n;
    assign DbgGnt     = port_dbg;
    assign MemAddress = port_dbg ? DbgAddr : pc_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:    if (Halt)  state_d = ST_HALTED;
            ST_HALTED: if (!Halt) state_d = ST_RUN;
            ST_FAULT:  state_d = ST_FAULT;
            default:   state_d = ST_RUN;
        endcase
        if (redirect_bad) begin
            state_d = ST_FAULT;
        end
    end

    always_comb begin
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        fault_d       = fault_q;

        if (redirect_take) begin
            // A redirect always flushes, even when decode is taking the entry this cycle.
            instr_valid_d = 1'b0;
            if (redirect_bad) begin
                fault_d = 1'b1;
            end else begin
                pc_d = RedirectPC;
            end
        end else if (fetch_fire) begin
            instr_d       = MemInstruction;
            instr_pc_d    = pc_q;
            instr_valid_d = 1'b1;
            pc_d          = pc_q + 32'd4;
        end else if (instr_valid_q && InstrReady) begin
            instr_valid_d = 1'b0;
        end
    end

    always_comb begin
        last_dbg_d  = dbg_win;
        dbg_valid_d = dbg_win;
        dbg_data_d  = dbg_win ? MemInstruction : dbg_data_q;
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            instr_q       <= 32'h0;
            instr_pc_q    <= 32'h0;
            instr_valid_q <= 1'b0;
            dbg_data_q    <= 32'h0;
            dbg_valid_q   <= 1'b0;
            fault_q       <= 1'b0;
            last_dbg_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            dbg_data_q    <= dbg_data_d;
            dbg_valid_q   <= dbg_valid_d;
            fault_q       <= fault_d;
            last_dbg_q    <= last_dbg_d;
        end
    end

    assign Instruction = instr_q;
    assign InstrPC     = instr_pc_q;
    assign InstrValid  = instr_valid_q;
    assign DbgData     = dbg_data_q;
    assign DbgValid    = dbg_valid_q;
    assign Fault       = fault_q;

endmodule
